// File: rtl/scan_link_pkg.sv
// Shared types and constants for the scanner link arbiter and its serializer.
package scan_link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } link_state_t;

    localparam logic [7:0] READY_TO_TRANSFER = 8'd2;
    localparam logic [7:0] START_SCANNING    = 8'd3;
    localparam logic [7:0] BUFFER_FULL       = 8'd4;
    localparam logic [7:0] DATA_FOLLOWS      = 8'd7;

    localparam int DEFAULT_DIV = 8;

endpackage

// File: rtl/scan_link_arbiter_link_serializer.sv
// Shifts a one- or two-byte frame out LSB first, one bit per DIV clocks,
// with a registered link clock that is low for the first half of each bit.
module link_serializer
    import scan_link_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        length,
    input  logic [15:0] frame,
    output logic        clkOut,
    output logic        dataOut,
    output logic        last
);

    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_MID  = DW'(DIV / 2 - 1);

    logic [15:0]   shreg;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic          active;
    logic          second;
    logic          two_bytes;

    // Pulses on the final clock of every byte; the FSM decides what follows.
    assign last = active && (div_cnt == DIV_LAST) && (bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            active    <= 1'b0;
            second    <= 1'b0;
            two_bytes <= 1'b0;
            clkOut    <= 1'b0;
            dataOut   <= 1'b0;
        end else if (load) begin
            shreg     <= frame;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            active    <= 1'b1;
            second    <= 1'b0;
            two_bytes <= length;
            clkOut    <= 1'b0;
            dataOut   <= frame[0];
        end else if (active) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (div_cnt == DIV_MID) begin
                clkOut <= 1'b1;
            end
            if (div_cnt == DIV_LAST) begin
                clkOut  <= 1'b0;
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {1'b0, shreg[15:1]};
                if (last && (second || !two_bytes)) begin
                    active  <= 1'b0;
                    dataOut <= 1'b0;
                end else begin
                    dataOut <= shreg[1];
                    if (bit_cnt == 3'd7) begin
                        second <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/scan_link_arbiter.sv
// Round-robin owner of the shared serial link between two scanners;
// the granted scanner's frame is latched at grant and serialized.
//
// state | meaning
// IDLE  | link free, waiting for any req
// CMD   | shifting the command byte
// DATA  | shifting the data byte
// DONE  | one-cycle done pulse to the owner, link quiet
module scan_link_arbiter
    import scan_link_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] cmd0,
    input  logic [7:0] cmd1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [1:0] hasData,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic       busy,
    output logic       clkOut,
    output logic       dataOut
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CMD  = CMD;
    localparam logic [1:0] ST_DATA = DATA;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]  state;
    logic        ptr;
    logic        has_data_q;
    logic        winner;
    logic        load;
    logic        length;
    logic [15:0] frame;
    logic        ser_last;

    always_comb begin
        winner = ptr;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
        load   = (state == ST_IDLE) && (req != 2'b00);
        frame  = winner ? {data1, cmd1} : {data0, cmd0};
        length = winner ? hasData[1] : hasData[0];
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= 2'b00;
            done       <= 2'b00;
            ptr        <= 1'b0;
            has_data_q <= 1'b0;
        end else begin
            done <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        grant      <= winner ? 2'b10 : 2'b01;
                        ptr        <= ~winner;
                        has_data_q <= length;
                        state      <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (ser_last) begin
                        if (has_data_q) begin
                            state <= ST_DATA;
                        end else begin
                            state <= ST_DONE;
                            done  <= grant;
                            grant <= 2'b00;
                        end
                    end
                end
                ST_DATA: begin
                    if (ser_last) begin
                        state <= ST_DONE;
                        done  <= grant;
                        grant <= 2'b00;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    link_serializer #(.DIV(DIV)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .length  (length),
        .frame   (frame),
        .clkOut  (clkOut),
        .dataOut (dataOut),
        .last    (ser_last)
    );

endmodule

// File: doc/scan_link_arbiter.md
# scan_link_arbiter

Arbitrates the shared serial output link between two scanner blocks and serializes the granted scanner's frame onto `clkOut`/`dataOut`. Each frame is an 8-bit command byte, optionally followed by an 8-bit data byte. Requesters are served round-robin, one frame at a time. The block sits between the scanners' command/data outputs and the off-chip link.

## Interface
Parameters:
- `DIV`, default 8: clk cycles per serial bit. Must be even and ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous, active-high.
- `req`  in  2  per-scanner frame request; bit i is scanner i.
- `cmd0`, `cmd1`  in  8  command byte of scanner 0 / 1.
- `data0`, `data1`  in  8  data byte of scanner 0 / 1.
- `hasData`  in  2  bit i set: scanner i's frame includes its data byte.
- `grant`  out  2  one-hot owner of the link; 0 when idle.
- `done`  out  2  one-cycle pulse on bit i when scanner i's frame has finished.
- `busy`  out  1  high while a frame is in progress (states CMD/DATA/DONE).
- `clkOut`  out  1  link clock.
- `dataOut`  out  1  link data, LSB first.

## Operation
- States: IDLE, CMD, DATA, DONE.
- **Reset values:** state IDLE; `grant`=0, `done`=0, `busy`=0, `clkOut`=0, `dataOut`=0; priority pointer gives scanner 0 first priority.
- **IDLE**
  - At an edge with `req`≠0, pick the winner:
    - Only one request set: that requester wins.
    - Both set: the requester the priority pointer selects wins.
  - On the same edge: register `grant`, latch the winner's cmd/data/hasData into the shift register, move the pointer to the other requester, enter CMD.
- **CMD**
  - Shifts the 8 command bits, LSB first, each held for DIV cycles.
  - After the 8th bit: go to DATA if the latched hasData=1, otherwise DONE.
- **DATA:** shifts the 8 latched data bits the same way, then goes to DONE.
- **DONE:** lasts one cycle.
  - `done[owner]`=1.
  - `grant`=0, `dataOut`=0, `clkOut`=0.
  - Always returns to IDLE.
- Inputs are latched at grant. Changes to cmd/data/hasData/req during a frame have no effect.
- `req` dropping mid-frame does not abort the frame; `done` still pulses.
- A `req` still high after `done` is treated as a new request in IDLE. Requesters drop `req` on `done` if they have nothing further to send.
- A request withdrawn before it is granted leaves no state behind.
- Async reset mid-frame:
  - All outputs go to reset values immediately.
  - The frame is abandoned with no `done` pulse.
  - The pointer returns to scanner 0.

## Timing
- Grant edge = cycle 0. `grant`, `busy` and bit 0 on `dataOut` are valid from cycle 0.
- Bit k of the frame occupies cycles k·DIV to k·DIV+DIV−1:
  - `clkOut`=0 for the first DIV/2 of those cycles and 1 for the last DIV/2.
  - The receiver samples on the `clkOut` rising edge.
- DONE occupies cycle 8·DIV (command-only frame) or 16·DIV (frame with data).
- IDLE follows for at least one cycle, so back-to-back frames have a 2-cycle gap with `dataOut`=0 and `clkOut`=0.
- Counters:
  - Divider is $clog2(DIV) bits and wraps at DIV−1.
  - Bit counter is 3 bits and wraps 7→0 at each byte boundary.
  - No other arithmetic.
- `clkOut` is a registered output; it is never derived from `clk` combinationally.

## Structure
- Shared package `scan_link_pkg` holds:
  - The state enum: IDLE, CMD, DATA, DONE.
  - Command codes: READY_TO_TRANSFER=8'd2, START_SCANNING=8'd3, BUFFER_FULL=8'd4, DATA_FOLLOWS=8'd7.
  - The default DIV.
- One sub-module, `link_serializer`:
  - Contains the 16-bit shift register, DIV divider and bit counter.
  - Interface: load/length in, `clkOut`/`dataOut`/`last` out.
- The arbiter FSM and round-robin pointer stay in the top module.

## Test plan
All scenarios use DIV=8.
- **Reset:** assert `rst` asynchronously between edges → all outputs 0 immediately and held while reset is high.
- **Command-only frame:** `req`=01, `cmd0`=8'h02, `hasData`=00.
  - `grant`=01 and `busy`=1 from the grant edge.
  - `dataOut` bits 0,1,0,0,0,0,0,0, each lasting 8 cycles.
  - `clkOut` runs 4 low / 4 high per bit.
  - `done`=01 for exactly cycle 64, then `grant`=00.
- **Frame with data:** `req`=10, `cmd1`=8'h07, `data1`=8'hA5, `hasData`=10.
  - 16 bits on `dataOut`: 1,1,1,0,0,0,0,0 then 1,0,1,0,0,1,0,1.
  - `done`=10 at cycle 128.
- **Contention:** `req`=11 held continuously → grants 01, 10, 01, 10 with a 2-cycle gap between frames; no starvation.
- **Robustness:**
  - `req0` dropped and `cmd0` changed at cycle 20 → transmitted bits unchanged and `done` still at cycle 64.
  - `rst` pulse at cycle 30 → outputs 0 immediately and no `done`; with `req`=11 afterwards the next grant is 01.
